mac_mul_block_pipe: RTL and testbench



---
 rtl/mac_mul_block_pipe_pkg.sv | 22 ++
 rtl/mac_pipe_ctrl.sv | 57 +++++
 rtl/mac_mul_block_pipe.sv | 169 ++++++++++++++++
 tb/tb_mac_mul_block_pipe.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mac_mul_block_pipe_pkg.sv
// Shared constants for the limb multiplier pipeline: mode encodings,
// default limb width and the operand-width helper.
package mac_mul_block_pipe_pkg;

  localparam int unsigned MAC_MIN_WIDTH_DEF = 8;
  localparam int unsigned MAC_CONF_WIDTH_DEF = 2;

  localparam logic [1:0] MAC_CFG_SINGLE  = 2'd0;
  localparam logic [1:0] MAC_CFG_DUAL    = 2'd1;
  localparam logic [1:0] MAC_CFG_QUAD    = 2'd2;
  localparam logic [1:0] MAC_CFG_ILLEGAL = 2'd3;

  function automatic int unsigned mac_op_width(input logic [1:0] cfg, input int unsigned w);
    case (cfg)
      MAC_CFG_SINGLE: return w;
      MAC_CFG_DUAL:   return 2 * w;
      MAC_CFG_QUAD:   return 4 * w;
      default:        return 0;
    endcase
  endfunction

endpackage

// File: rtl/mac_pipe_ctrl.sv
// Generic N-stage valid/ready advance controller; a stage advances when it is
// empty or its successor advances, and a global enable freezes everything.
module mac_pipe_ctrl #(
  parameter int unsigned N_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic                out_ready,
  output logic                in_ready,
  output logic                out_valid,
  output logic [N_STAGES-1:0] stage_ld
);

  localparam int NS = int'(N_STAGES);

  logic [N_STAGES-1:0] vld_q, vld_d;
  logic [N_STAGES-1:0] adv_s;
  logic                chain_s;

  // Advance chain runs from the output stage back to the input stage
  always_comb begin
    chain_s = en & (~vld_q[NS-1] | out_ready);
    adv_s   = '0;
    adv_s[NS-1] = chain_s;
    for (int i = NS - 2; i >= 0; i--) begin
      chain_s  = en & (~vld_q[i] | chain_s);
      adv_s[i] = chain_s;
    end
  end

  // Next-state valids and data load enables
  always_comb begin
    vld_d       = vld_q;
    stage_ld    = '0;
    vld_d[0]    = adv_s[0] ? in_valid : vld_q[0];
    stage_ld[0] = adv_s[0] & in_valid;
    for (int i = 1; i < NS; i++) begin
      vld_d[i]    = adv_s[i] ? vld_q[i-1] : vld_q[i];
      stage_ld[i] = adv_s[i] & vld_q[i-1];
    end
  end

  // Stage valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign in_ready  = adv_s[0] & ~rst;
  assign out_valid = vld_q[NS-1];

endmodule

// File: rtl/mac_mul_block_pipe.sv
// Two-stage flow-controlled limb multiplier: S1 holds the W x W limb products,
// S2 the mode-masked carry-chain sum with the two's-complement correction.
module mac_mul_block_pipe
  import mac_mul_block_pipe_pkg::*;
#(
  parameter int unsigned MAC_CONF_WIDTH = MAC_CONF_WIDTH_DEF,
  parameter int unsigned MAC_MIN_WIDTH  = MAC_MIN_WIDTH_DEF,
  parameter int unsigned MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
  parameter int unsigned MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
  parameter int unsigned MAC_TAG_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MAC_CONF_WIDTH-1:0]  cfg,
  input  logic                       sgn,
  input  logic [4*MAC_MIN_WIDTH-1:0] A,
  input  logic [MAC_MIN_WIDTH-1:0]   B0,
  input  logic [MAC_TAG_WIDTH-1:0]   in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAC_INT_WIDTH-1:0]   C,
  output logic                       out_err,
  output logic [MAC_TAG_WIDTH-1:0]   out_tag
);

  localparam int unsigned W = MAC_MIN_WIDTH;
  localparam int unsigned PP_PAD = MAC_INT_WIDTH - MAC_MULT_WIDTH;

  logic [1:0] stage_ld_s;

  mac_pipe_ctrl #(.N_STAGES(2)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .stage_ld  (stage_ld_s)
  );

  logic [MAC_MULT_WIDTH-1:0] pp_d [4];
  logic [MAC_MULT_WIDTH-1:0] s1_pp_q [4];
  logic [4*W-1:0]            a_op_d, s1_a_q;
  logic                      a_neg_d, b_neg_d, s1_a_neg_q, s1_b_neg_q;
  logic [MAC_CONF_WIDTH-1:0] s1_cfg_q;
  logic                      s1_sgn_q;
  logic [W-1:0]              s1_b_q;
  logic [MAC_TAG_WIDTH-1:0]  s1_tag_q;

  // S1 next state: limb products plus the mode-width operand and its sign
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp_d[i] = {{W{1'b0}}, A[i*W +: W]} * {{W{1'b0}}, B0};
    end
    a_op_d  = '0;
    a_neg_d = 1'b0;
    case (cfg)
      MAC_CFG_SINGLE: begin
        a_op_d[W-1:0] = A[W-1:0];
        a_neg_d       = sgn & A[W-1];
      end
      MAC_CFG_DUAL: begin
        a_op_d[2*W-1:0] = A[2*W-1:0];
        a_neg_d         = sgn & A[2*W-1];
      end
      MAC_CFG_QUAD: begin
        a_op_d  = A;
        a_neg_d = sgn & A[4*W-1];
      end
      default: begin
        a_op_d  = '0;
        a_neg_d = 1'b0;
      end
    endcase
    b_neg_d = sgn & B0[W-1];
  end

  // S1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) s1_pp_q[i] <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cfg_q   <= '0;
      s1_sgn_q   <= 1'b0;
      s1_tag_q   <= '0;
      s1_a_neg_q <= 1'b0;
      s1_b_neg_q <= 1'b0;
    end else if (stage_ld_s[0]) begin
      for (int i = 0; i < 4; i++) s1_pp_q[i] <= pp_d[i];
      s1_a_q     <= a_op_d;
      s1_b_q     <= B0;
      s1_cfg_q   <= cfg;
      s1_sgn_q   <= sgn;
      s1_tag_q   <= in_tag;
      s1_a_neg_q <= a_neg_d;
      s1_b_neg_q <= b_neg_d;
    end
  end

  int unsigned              opw_s;
  logic [MAC_INT_WIDTH-1:0] sum_s, corr_a_s, corr_b_s, c_d, c_q;
  logic                     err_d, err_q;
  logic [MAC_TAG_WIDTH-1:0] tag_q;

  // S2 next state; the corrections are exact modulo 2^(opw+W), so the
  // result is sign-extended from that width
  always_comb begin
    opw_s = mac_op_width(s1_cfg_q, W);
    sum_s = {{PP_PAD{1'b0}}, s1_pp_q[0]};
    case (s1_cfg_q)
      MAC_CFG_DUAL: begin
        sum_s = sum_s + ({{PP_PAD{1'b0}}, s1_pp_q[1]} << W);
      end
      MAC_CFG_QUAD: begin
        sum_s = sum_s + ({{PP_PAD{1'b0}}, s1_pp_q[1]} << W)
                      + ({{PP_PAD{1'b0}}, s1_pp_q[2]} << (2*W))
                      + ({{PP_PAD{1'b0}}, s1_pp_q[3]} << (3*W));
      end
      default: begin
        sum_s = sum_s;
      end
    endcase
    corr_a_s = s1_a_neg_q ? ({{(MAC_INT_WIDTH-W){1'b0}}, s1_b_q} << opw_s) : '0;
    corr_b_s = s1_b_neg_q ? ({{(MAC_INT_WIDTH-4*W){1'b0}}, s1_a_q} << W) : '0;
    sum_s    = sum_s - corr_a_s - corr_b_s;
    err_d    = 1'b0;
    c_d      = sum_s;
    case (s1_cfg_q)
      MAC_CFG_SINGLE: begin
        if (s1_sgn_q) c_d = {{(MAC_INT_WIDTH-2*W){sum_s[2*W-1]}}, sum_s[2*W-1:0]};
        else          c_d = sum_s;
      end
      MAC_CFG_DUAL: begin
        if (s1_sgn_q) c_d = {{(MAC_INT_WIDTH-3*W){sum_s[3*W-1]}}, sum_s[3*W-1:0]};
        else          c_d = sum_s;
      end
      MAC_CFG_QUAD: begin
        c_d = sum_s;
      end
      default: begin
        c_d   = '0;
        err_d = 1'b1;
      end
    endcase
  end

  // S2 registers drive the result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= '0;
      err_q <= 1'b0;
      tag_q <= '0;
    end else if (stage_ld_s[1]) begin
      c_q   <= c_d;
      err_q <= err_d;
      tag_q <= s1_tag_q;
    end
  end

  assign C       = c_q;
  assign out_err = err_q;
  assign out_tag = tag_q;

endmodule

// File: tb/tb_mac_mul_block_pipe.sv
// Scoreboard bench: the driver queues expected results on accept, a monitor
// pops and compares on every output handshake.
module tb_mac_mul_block_pipe;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, in_ready, sgn, out_valid, out_ready, out_err;
  logic [1:0]  cfg;
  logic [31:0] A;
  logic [7:0]  B0;
  logic [3:0]  in_tag, out_tag;
  logic [39:0] C;

  typedef struct packed {
    logic [39:0] c;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [39:0] c_hold;

  mac_mul_block_pipe dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .cfg(cfg), .sgn(sgn), .A(A), .B0(B0), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .C(C), .out_err(out_err),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a negedge; leaves in_valid high so beats can go back-to-back
  task automatic send(input logic [1:0] cfg_v, input logic sgn_v, input logic [31:0] a_v,
                      input logic [7:0] b_v, input logic [3:0] tag_v,
                      input logic [39:0] exp_c, input logic exp_err);
    bit done = 1'b0;
    exp_t e;
    cfg = cfg_v; sgn = sgn_v; A = a_v; B0 = b_v; in_tag = tag_v; in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (in_ready) begin
        e.c = exp_c; e.err = exp_err; e.tag = tag_v;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag=%h actual=no_accept required=accept", tag_v);
    end
  endtask

  // Monitor: decides at mid-cycle whether the next edge pops a result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && en && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=C:%h tag:%h required=none", C, out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("result_C", C, e.c);
          chk("result_err", {39'd0, out_err}, {39'd0, e.err});
          chk("result_tag", {36'd0, out_tag}, {36'd0, e.tag});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cfg = 2'd0; sgn = 1'b0; A = 32'd0; B0 = 8'd0; in_tag = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_valid", {39'd0, out_valid}, 40'd0);
    chk("rst_in_ready", {39'd0, in_ready}, 40'd0);
    chk("rst_C", C, 40'd0);
    chk("rst_out_err", {39'd0, out_err}, 40'd0);
    chk("rst_out_tag", {36'd0, out_tag}, 40'd0);
    rst = 1'b0;
    @(negedge clk);

    // Latency: result is presented one cycle after the beat sits in S1
    send(2'd0, 1'b0, 32'h0000_00FF, 8'hFF, 4'h1, 40'h00_0000_FE01, 1'b0);
    in_valid = 1'b0;
    #1 chk("latency_s1_only", {39'd0, out_valid}, 40'd0);
    @(negedge clk);
    #1 chk("latency_out_valid", {39'd0, out_valid}, 40'd1);
    repeat (2) @(negedge clk);

    // Per-mode directed vectors, issued back-to-back
    send(2'd1, 1'b0, 32'h0000_FFFF, 8'hFF, 4'h2, 40'h00_00FE_FF01, 1'b0);
    send(2'd2, 1'b0, 32'hFFFF_FFFF, 8'hFF, 4'h3, 40'hFE_FFFF_FF01, 1'b0);
    send(2'd0, 1'b1, 32'h0000_0080, 8'h02, 4'h4, 40'hFF_FFFF_FF00, 1'b0);
    send(2'd2, 1'b1, 32'hFFFF_FFFF, 8'h03, 4'h5, 40'hFF_FFFF_FFFD, 1'b0);
    send(2'd1, 1'b1, 32'h0000_7FFF, 8'h81, 4'h6, 40'hFF_FFC0_807F, 1'b0);
    send(2'd0, 1'b1, 32'h0000_00FF, 8'hFF, 4'h7, 40'h00_0000_0001, 1'b0);
    send(2'd2, 1'b1, 32'h8000_0000, 8'h80, 4'h8, 40'h40_0000_0000, 1'b0);
    send(2'd0, 1'b0, 32'hDEAD_BE05, 8'h03, 4'h9, 40'h00_0000_000F, 1'b0);
    // Mixed-precision stream ending with an illegal cfg
    send(2'd0, 1'b0, 32'h0000_0012, 8'h34, 4'h1, 40'h00_0000_03A8, 1'b0);
    send(2'd1, 1'b0, 32'h0000_1234, 8'h10, 4'h2, 40'h00_0001_2340, 1'b0);
    send(2'd2, 1'b0, 32'h1234_5678, 8'h02, 4'h3, 40'h00_2468_ACF0, 1'b0);
    send(2'd3, 1'b1, 32'hFFFF_FFFF, 8'hFF, 4'h4, 40'h00_0000_0000, 1'b1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Backpressure: two beats fill the pipe, the third waits for the first pop
    out_ready = 1'b0;
    send(2'd0, 1'b0, 32'h0000_0002, 8'h03, 4'h5, 40'h00_0000_0006, 1'b0);
    send(2'd0, 1'b0, 32'h0000_0004, 8'h05, 4'h6, 40'h00_0000_0014, 1'b0);
    c_hold = C;
    fork
      send(2'd0, 1'b0, 32'h0000_0007, 8'h07, 4'h7, 40'h00_0000_0031, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk); #1;
          chk("bp_in_ready_low", {39'd0, in_ready}, 40'd0);
          chk("bp_C_stable", C, c_hold);
          chk("bp_out_valid", {39'd0, out_valid}, 40'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("bp_release_accept", {39'd0, in_ready}, 40'd1);
      end
    join
    in_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Global stall with a full pipe and out_ready high
    send(2'd0, 1'b0, 32'h0000_0010, 8'h10, 4'h8, 40'h00_0000_0100, 1'b0);
    send(2'd0, 1'b0, 32'h0000_0011, 8'h11, 4'h9, 40'h00_0000_0121, 1'b0);
    en = 1'b0; A = 32'hFFFF_FFFF; B0 = 8'hFF; in_tag = 4'hF;
    c_hold = C;
    repeat (3) begin
      @(negedge clk); #1;
      chk("stall_in_ready", {39'd0, in_ready}, 40'd0);
      chk("stall_C_frozen", C, c_hold);
      chk("stall_out_valid", {39'd0, out_valid}, 40'd1);
    end
    @(negedge clk);
    en = 1'b1;
    send(2'd0, 1'b0, 32'h0000_0020, 8'h02, 4'hA, 40'h00_0000_0040, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset with two beats in flight discards them
    send(2'd0, 1'b0, 32'h0000_0005, 8'h05, 4'hB, 40'h00_0000_0019, 1'b0);
    send(2'd0, 1'b0, 32'h0000_0006, 8'h06, 4'hC, 40'h00_0000_0024, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("midrst_out_valid", {39'd0, out_valid}, 40'd0);
    chk("midrst_C", C, 40'd0);
    chk("midrst_in_ready", {39'd0, in_ready}, 40'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(2'd0, 1'b0, 32'h0000_0003, 8'h03, 4'hD, 40'h00_0000_0009, 1'b0);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);

    chk("scoreboard_drained", 40'(exp_q.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
